wb_multi_commit: RTL and testbench
==================================

// Module: wb_multi_commit
// PURPOSE
//  Parametrised multi-source writeback stage: NUM_SRC result channels (ALU, LSU, MUL/DIV, ...) compete for
//  a single register-file write port. Arbitrates one source per cycle, formats load data (LB/LH/LW/LBU/LHU),
//  registers the winning write, drives it to the register file and EX forwarding, and counts retirements.
//  Sits between the EX/MEM result producers and the register file.
// PARAMETERS
//  DATA_W    32  register data width
//  ADDR_W    5   register address width
//  NUM_SRC   3   number of result channels (>=1)
//  ARB_MODE  0   0 = round-robin, 1 = fixed priority (lowest index wins)
//  CNT_W     32  width of retire counter
// PORTS
//  clk            in   1                  clock, all state on rising edge
//  rst_n          in   1                  synchronous reset, active low
//  src_valid      in   NUM_SRC            channel i holds a result
//  src_ready      out  NUM_SRC            channel i accepted this cycle (one-hot or zero)
//  src_rd_addr    in   NUM_SRC x ADDR_W   destination register per channel
//  src_data       in   NUM_SRC x DATA_W   raw result / raw load word per channel
//  src_is_load    in   NUM_SRC            apply load formatting to src_data
//  src_ld_funct3  in   NUM_SRC x 3        load type (RV32I funct3)
//  src_ld_offset  in   NUM_SRC x 2        byte offset of load address
//  reg_wr_en      out  1                  register-file write enable
//  reg_wr_addr    out  ADDR_W             register-file write address
//  reg_wr_data    out  DATA_W             register-file write data
//  forward_valid  out  1                  forward payload valid (= reg_wr_en)
//  forward_addr   out  ADDR_W             forward address (= reg_wr_addr)
//  forward_data   out  DATA_W             forward data (= reg_wr_data)
//  retire_cnt     out  CNT_W              number of accepted results since reset
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, retire_cnt=0, rr_ptr=0.
//    src_ready is forced 0 while rst_n=0; a transfer presented in the reset cycle is not accepted.
//  - Handshake: transfer on src_valid[i] & src_ready[i]. src_ready is combinational from src_valid and rr_ptr;
//    at most one bit set; src_ready[i] never asserted without src_valid[i]. Sources hold payload until accepted.
//  - Arbitration: ARB_MODE=0 grants first valid index at or after rr_ptr (wrapping); on grant rr_ptr <= g+1
//    mod NUM_SRC; no grant -> rr_ptr unchanged. ARB_MODE=1 grants lowest valid index; rr_ptr unused.
//  - Latency: accept in cycle N -> reg_wr_en=1 with addr/data in cycle N+1, for exactly one cycle per transfer.
//    Back-to-back accepts give back-to-back writes; no accept in N -> reg_wr_en=0 in N+1 (addr/data hold).
//  - x0: rd_addr=0 is accepted and counted but produces reg_wr_en=0 (addr/data still registered).
//  - Load formatting (src_is_load=1), funct3: 000 LB sign-ext byte[offset]; 100 LBU zero-ext byte[offset];
//    001 LH sign-ext half[offset[1]]; 101 LHU zero-ext half[offset[1]]; 010 and others -> word unchanged.
//    offset[0] ignored for halves. src_is_load=0 -> src_data unchanged.
//  - retire_cnt +1 per accepted transfer (incl. x0); wraps to 0 at 2^CNT_W-1 +1, no saturation.
//  - Same rd from two channels: written in grant order in successive cycles; last grant's value persists.
//  - Forwarding outputs are wires from the registered write stage (zero extra latency vs regfile write).
//  - Reset mid-operation: registered write dropped, pending sources stay unaccepted, counter and pointer clear.
// STRUCTURE
//  - wb_pkg: ld_funct3_e enum (LB,LH,LW,LBU,LHU), ARB_RR/ARB_FIXED constants, load_format() function.
//  - Sub-module wb_rr_arbiter (NUM_SRC, ARB_MODE): req -> one-hot grant + grant index, owns rr_ptr.
//  - Top: per-source load formatting, grant mux, output register, retire counter.
// TESTING
//  1 Reset: rst_n=0 2 cycles with src_valid=3'b111 -> src_ready=0, reg_wr_en=0, retire_cnt=0 after release.
//  2 RR: NUM_SRC=3, all valid for 6 cycles -> grants 0,1,2,0,1,2; reg_wr_en=1 cycles 2..7; retire_cnt=6.
//  3 Fixed prio (ARB_MODE=1): src0,src2 valid for 2 cycles, src0 drops after 1 -> grants 0 then 2.
//  4 Loads: data=32'h8081_F0F7, LB off3 -> FFFF_FF80; LBU off0 -> 0000_00F7; LH off2 -> FFFF_8081;
//    LHU off1 -> 0000_F0F7; LW -> 8081_F0F7.
//  5 x0 and same-rd: src0 rd=0 data=5 -> reg_wr_en=0, retire_cnt+1; src0,src1 both rd=7 data 1/2 -> x7=2.
//  6 Counter wrap (CNT_W=4): 17 accepts -> retire_cnt=1; reset asserted mid-burst -> outputs 0 next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the multi-source writeback stage.
// Holds the arbitration mode constants, the RV32I load encodings and load formatting.
package wb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_funct3_e;

    // Extracts and extends the addressed byte/half of a raw load word.
    // Half selection uses offset[1] only; unknown encodings pass the word through.
    function automatic logic [31:0] load_format(input logic [31:0] raw,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = 8'(raw >> {offset, 3'b000});
        h   = offset[1] ? raw[31:16] : raw[15:0];
        res = raw;
        case (ld_funct3_e'(funct3))
            LD_LB:   res = {{24{b[7]}}, b};
            LD_LBU:  res = {24'd0, b};
            LD_LH:   res = {{16{h[15]}}, h};
            LD_LHU:  res = {16'd0, h};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// One-hot arbiter for the writeback port: round-robin from rr_ptr or fixed lowest-index priority.
// The pointer only moves when something is granted.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC  = 3,
    parameter int ARB_MODE = ARB_RR,
    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0] rr_ptr;

    // Scan NUM_SRC slots starting at the base index, wrapping without a modulo operator.
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = (ARB_MODE == ARB_FIXED) ? k : int'(rr_ptr) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!grant_vld && req[j]) begin
                grant_vld = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (ARB_MODE == ARB_RR && grant_vld) begin
            rr_ptr <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wb_multi_commit.sv
// Writeback stage: arbitrates NUM_SRC result channels onto one register-file write port,
// formats load data, registers the winning write (also used as the forward path) and counts retirements.
module wb_multi_commit
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 3,
    parameter int ARB_MODE = ARB_RR,
    parameter int CNT_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC-1:0][ADDR_W-1:0]  src_rd_addr,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data,
    input  logic [NUM_SRC-1:0]              src_is_load,
    input  logic [NUM_SRC-1:0][2:0]         src_ld_funct3,
    input  logic [NUM_SRC-1:0][1:0]         src_ld_offset,
    output logic                            reg_wr_en,
    output logic [ADDR_W-1:0]               reg_wr_addr,
    output logic [DATA_W-1:0]               reg_wr_data,
    output logic                            forward_valid,
    output logic [ADDR_W-1:0]               forward_addr,
    output logic [DATA_W-1:0]               forward_data,
    output logic [CNT_W-1:0]                retire_cnt
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]             req;
    logic [NUM_SRC-1:0]             grant;
    logic [IDX_W-1:0]               grant_idx;
    logic                           accept;
    logic [NUM_SRC-1:0][DATA_W-1:0] fmt_data;
    logic [ADDR_W-1:0]              sel_addr;
    logic [DATA_W-1:0]              sel_data;

    // Nothing is accepted while reset is held, so sources keep their payload across it.
    assign req = src_valid & {NUM_SRC{rst_n}};

    wb_rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (accept)
    );

    assign src_ready = grant;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fmt
        assign fmt_data[i] = src_is_load[i]
            ? DATA_W'(load_format(32'(src_data[i]), src_ld_funct3[i], src_ld_offset[i]))
            : src_data[i];
    end

    assign sel_addr = src_rd_addr[grant_idx];
    assign sel_data = fmt_data[grant_idx];

    // x0 writes still retire and update addr/data, but never raise the write enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            retire_cnt  <= '0;
        end else begin
            reg_wr_en <= accept && (sel_addr != '0);
            if (accept) begin
                reg_wr_addr <= sel_addr;
                reg_wr_data <= sel_data;
                retire_cnt  <= retire_cnt + 1'b1;
            end
        end
    end

    assign forward_valid = reg_wr_en;
    assign forward_addr  = reg_wr_addr;
    assign forward_data  = reg_wr_data;

endmodule

// File: tb/tb_wb_multi_commit.sv
// Directed bench: three instances (round-robin, fixed priority, 4-bit counter) share one stimulus stream.
module tb_wb_multi_commit;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [2:0]           v;
    logic [2:0][4:0]      rd;
    logic [2:0][31:0]     dat;
    logic [2:0]           isld;
    logic [2:0][2:0]      f3;
    logic [2:0][1:0]      off;

    logic [2:0]  r_rdy,  x_rdy,  w_rdy;
    logic        r_en,   x_en,   w_en;
    logic [4:0]  r_addr, x_addr, w_addr;
    logic [31:0] r_data, x_data, w_data;
    logic        r_fv,   x_fv,   w_fv;
    logic [4:0]  r_fa,   x_fa,   w_fa;
    logic [31:0] r_fd,   x_fd,   w_fd;
    logic [31:0] r_cnt,  x_cnt;
    logic [3:0]  w_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_multi_commit #(.ARB_MODE(0), .CNT_W(32)) u_rr (
        .clk(clk), .rst_n(rst_n), .src_valid(v), .src_ready(r_rdy), .src_rd_addr(rd),
        .src_data(dat), .src_is_load(isld), .src_ld_funct3(f3), .src_ld_offset(off),
        .reg_wr_en(r_en), .reg_wr_addr(r_addr), .reg_wr_data(r_data),
        .forward_valid(r_fv), .forward_addr(r_fa), .forward_data(r_fd), .retire_cnt(r_cnt));

    wb_multi_commit #(.ARB_MODE(1), .CNT_W(32)) u_fx (
        .clk(clk), .rst_n(rst_n), .src_valid(v), .src_ready(x_rdy), .src_rd_addr(rd),
        .src_data(dat), .src_is_load(isld), .src_ld_funct3(f3), .src_ld_offset(off),
        .reg_wr_en(x_en), .reg_wr_addr(x_addr), .reg_wr_data(x_data),
        .forward_valid(x_fv), .forward_addr(x_fa), .forward_data(x_fd), .retire_cnt(x_cnt));

    wb_multi_commit #(.ARB_MODE(0), .CNT_W(4)) u_w (
        .clk(clk), .rst_n(rst_n), .src_valid(v), .src_ready(w_rdy), .src_rd_addr(rd),
        .src_data(dat), .src_is_load(isld), .src_ld_funct3(f3), .src_ld_offset(off),
        .reg_wr_en(w_en), .reg_wr_addr(w_addr), .reg_wr_data(w_data),
        .forward_valid(w_fv), .forward_addr(w_fa), .forward_data(w_fd), .retire_cnt(w_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] fn, input logic [1:0] o,
                           input logic [31:0] exp);
        f3[0]  = fn;
        off[0] = o;
        tick();
        chk({tag, "_en"},   {31'd0, r_en}, 32'd1);
        chk({tag, "_data"}, r_data, exp);
        chk({tag, "_fwd"},  r_fd, exp);
    endtask

    initial begin
        v    = 3'b111;
        rd   = {5'd3, 5'd2, 5'd1};
        dat  = {32'h33, 32'h22, 32'h11};
        isld = '0;
        f3   = '0;
        off  = '0;

        // Reset held two cycles with all sources valid
        tick();
        tick();
        #1;
        chk("rst_ready",  {29'd0, r_rdy}, 32'd0);
        chk("rst_wr_en",  {31'd0, r_en}, 32'd0);
        chk("rst_addr",   {27'd0, r_addr}, 32'd0);
        chk("rst_data",   r_data, 32'd0);
        chk("rst_cnt",    r_cnt, 32'd0);
        rst_n = 1'b1;
        v     = 3'b000;
        #1;
        chk("rel_cnt",    r_cnt, 32'd0);
        chk("rel_ready",  {29'd0, r_rdy}, 32'd0);

        // Round-robin, all valid for six cycles
        tick();
        v = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", {29'd0, r_rdy}, 32'(3'b001 << (k % 3)));
            if (k == 0) chk("fx_ready_all", {29'd0, x_rdy}, 32'd1);
            tick();
            chk("rr_en",   {31'd0, r_en}, 32'd1);
            chk("rr_addr", {27'd0, r_addr}, 32'((k % 3) + 1));
            chk("rr_data", r_data, 32'(((k % 3) + 1) * 32'h11));
            chk("rr_fwd_addr", {27'd0, r_fa}, 32'((k % 3) + 1));
        end
        v = 3'b000;
        #1;
        chk("idle_ready", {29'd0, r_rdy}, 32'd0);
        tick();
        chk("idle_en",   {31'd0, r_en}, 32'd0);
        chk("idle_fv",   {31'd0, r_fv}, 32'd0);
        chk("idle_addr_hold", {27'd0, r_addr}, 32'd3);
        chk("rr_cnt6",   r_cnt, 32'd6);
        chk("fx_cnt6",   x_cnt, 32'd6);
        chk("fx_addr_all", {27'd0, x_addr}, 32'd1);

        // Fixed priority: src0 and src2, then src0 drops
        v = 3'b101;
        #1;
        chk("fx_ready_101", {29'd0, x_rdy}, 32'd1);
        tick();
        chk("fx_addr0", {27'd0, x_addr}, 32'd1);
        v = 3'b100;
        #1;
        chk("fx_ready_100", {29'd0, x_rdy}, 32'd4);
        tick();
        chk("fx_addr2", {27'd0, x_addr}, 32'd3);
        chk("fx_data2", x_data, 32'h33);
        chk("fx_cnt8",  x_cnt, 32'd8);

        // Load formatting on src0
        v       = 3'b001;
        isld[0] = 1'b1;
        dat[0]  = 32'h8081_F0F7;
        do_load("lb_off3",  3'b000, 2'd3, 32'hFFFF_FF80);
        do_load("lbu_off0", 3'b100, 2'd0, 32'h0000_00F7);
        do_load("lh_off2",  3'b001, 2'd2, 32'hFFFF_8081);
        do_load("lhu_off1", 3'b101, 2'd1, 32'h0000_F0F7);
        do_load("lw",       3'b010, 2'd0, 32'h8081_F0F7);
        isld[0] = 1'b0;
        chk("ld_cnt13", r_cnt, 32'd13);

        // x0 write: counted, no enable
        rd[0]  = 5'd0;
        dat[0] = 32'd5;
        tick();
        chk("x0_en",   {31'd0, r_en}, 32'd0);
        chk("x0_fv",   {31'd0, r_fv}, 32'd0);
        chk("x0_data", r_data, 32'd5);
        chk("x0_cnt",  r_cnt, 32'd14);

        // src2 alone brings the round-robin pointer back to 0
        v      = 3'b100;
        rd[2]  = 5'd9;
        dat[2] = 32'd9;
        tick();
        chk("rd9_addr", {27'd0, r_addr}, 32'd9);
        chk("w_cnt15",  {28'd0, w_cnt}, 32'd15);

        // Same rd from src0 and src1
        v      = 3'b011;
        rd[0]  = 5'd7;
        dat[0] = 32'd1;
        rd[1]  = 5'd7;
        dat[1] = 32'd2;
        #1;
        chk("same_ready0", {29'd0, r_rdy}, 32'd1);
        tick();
        chk("same_first", r_data, 32'd1);
        chk("w_cnt_wrap0", {28'd0, w_cnt}, 32'd0);
        v = 3'b010;
        tick();
        chk("same_second", r_data, 32'd2);
        chk("w_cnt17", {28'd0, w_cnt}, 32'd1);
        chk("r_cnt17", r_cnt, 32'd17);
        v = 3'b000;
        tick();
        chk("x7_persist", r_data, 32'd2);
        chk("x7_addr",    {27'd0, r_addr}, 32'd7);

        // Burst, then reset mid-operation
        rd  = {5'd3, 5'd2, 5'd1};
        dat = {32'h33, 32'h22, 32'h11};
        v   = 3'b111;
        #1;
        chk("burst_ready2", {29'd0, r_rdy}, 32'd4);
        tick();
        chk("burst_addr3", {27'd0, r_addr}, 32'd3);
        chk("burst_ready0", {29'd0, r_rdy}, 32'd1);
        tick();
        chk("burst_addr1", {27'd0, r_addr}, 32'd1);
        chk("burst_cnt19", r_cnt, 32'd19);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {29'd0, r_rdy}, 32'd0);
        tick();
        chk("mid_rst_en",   {31'd0, r_en}, 32'd0);
        chk("mid_rst_addr", {27'd0, r_addr}, 32'd0);
        chk("mid_rst_data", r_data, 32'd0);
        chk("mid_rst_cnt",  r_cnt, 32'd0);
        chk("mid_rst_wcnt", {28'd0, w_cnt}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ptr", {29'd0, r_rdy}, 32'd1);
        tick();
        chk("post_rst_en",   {31'd0, r_en}, 32'd1);
        chk("post_rst_addr", {27'd0, r_addr}, 32'd1);
        chk("post_rst_cnt",  r_cnt, 32'd1);
        v = 3'b000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
